button_bank: RTL and testbench
==============================

# button_bank

Parametrised N-channel pushbutton conditioner that replaces the per-button debounce instances in the Tamagotchi top level. Each channel is synchronised, polarity-corrected, debounced and classified into press, release and long-press events. Each channel also keeps a press counter, which generalises the test-button pulse count to every input. It sits between the board pins and FSM_Central.

## Interface
Parameters:
- N_CH, 5: number of button channels.
- ACTIVE_LOW_MASK, 5'b00110: bit i = 1 inverts channel i (pin low = pressed).
- DB_CYC, 1_000_000: debounce stability window in clk cycles (20 ms at 50 MHz); minimum 2.
- LONG_CYC, 50_000_000: hold time in cycles, measured from press_pulse, before long_pulse (1 s); must be greater than DB_CYC.
- CNT_W, 4: width of each press counter.
- CNT_WRAP, 1: 1 = counter wraps max→0; 0 = counter saturates at max.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  N_CH  raw asynchronous button pins.
- cnt_clr  in  N_CH  per-channel synchronous counter clear, level-sensitive.
- level  out  N_CH  debounced pressed state, 1 = pressed.
- press_pulse  out  N_CH  one-cycle strobe on debounced press.
- release_pulse  out  N_CH  one-cycle strobe on debounced release.
- long_pulse  out  N_CH  one-cycle strobe, at most once per press.
- press_cnt  out  N_CH*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Input path: 2-FF synchroniser per bit, then XOR with ACTIVE_LOW_MASK to give s_i (1 = pressed).
- Debounce:
  - Counter db_cnt resets to 0 whenever s_i equals level_i.
  - While s_i differs from level_i, db_cnt increments.
  - When db_cnt reaches DB_CYC-1 with s_i still differing, level_i toggles and db_cnt clears.
  - Any glitch shorter than DB_CYC cycles is rejected.
- Per-channel FSM:
  - IDLE → PRESSED when level rises: press_pulse=1, hold counter cleared.
  - PRESSED: hold counter increments each cycle. On reaching LONG_CYC-1 → HELD with long_pulse=1.
  - PRESSED or HELD → IDLE when level falls: release_pulse=1.
  - No long_pulse in HELD. Hold counter saturates and does not wrap.
- press_cnt increments on each press_pulse.
  - Wrap or saturate per CNT_WRAP.
  - cnt_clr=1 forces the counter to 0. If cnt_clr and press_pulse occur in the same cycle, the result is 1: clear first, then count, so the press is not lost.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset values: level=0, all pulses=0, press_cnt=0, FSM=IDLE, synchroniser FFs=0 after XOR correction.
  - An active-low pin is therefore treated as released at reset.
  - A button held through reset produces press_pulse DB_CYC+2 cycles after rst deasserts. This is intended.
- Latency: clean edge on btn_in at cycle 0 → level and press_pulse at cycle DB_CYC+2. Release is symmetric.
- long_pulse asserts exactly LONG_CYC cycles after press_pulse.
- If release occurs in the same cycle the hold counter would fire, release wins: release_pulse=1, long_pulse=0.
- press_cnt updates the cycle after press_pulse. cnt_clr takes effect the next cycle.
- rst mid-press: all state cleared in 1 cycle and no release_pulse is emitted.
- Pulses are always exactly 1 cycle wide. There is no back-to-back press_pulse on the same channel, because a minimum of 2*DB_CYC cycles separates presses.

## Structure
- Shared header tamagotchi_pkg holds:
  - Channel indices: CH_SLEEP=0, CH_FEED=1, CH_PLAY=2, CH_TEST=3, CH_RST=4.
  - Default ACTIVE_LOW_MASK.
  - Derived DB_CYC and LONG_CYC constants from CLK_HZ.
- Sub-module button_channel: synchroniser, debounce, FSM and counter for one bit. It is instantiated N_CH times via generate.
- Counter widths come from $clog2(DB_CYC) and $clog2(LONG_CYC).

## Test plan
Bench overrides: N_CH=5, DB_CYC=4, LONG_CYC=16, CNT_W=4.
- Glitch reject: 3-cycle high pulse on btn_in[0] → level, press_pulse and press_cnt[0] all stay 0.
- Clean press and release: btn_in[0] high at cycle 10 for 40 cycles.
  - press_pulse[0] at cycle 16.
  - long_pulse[0] at cycle 32.
  - release_pulse[0] at cycle 56.
  - press_cnt[0]=1.
- Active-low channel: btn_in[1] held 1 → no events. Drive btn_in[1] low for 10 cycles → press_pulse[1] 6 cycles after the falling edge, then a release, no long_pulse.
- Counter wrap and clear:
  - 16 presses on channel 3 → press_cnt[3] = 0. With CNT_WRAP=0 → 15.
  - cnt_clr[3] asserted in the same cycle as press_pulse[3] → count = 1.
- Concurrency and reset: channels 0 and 2 pressed on the same cycle → both press_pulses in the same cycle. rst asserted while HELD → all outputs 0 next cycle, no release_pulse.
- Release-at-long boundary: release timed so level falls on the cycle long_pulse would fire → release_pulse=1, long_pulse=0.

Source files
------------

// File: rtl/tamagotchi_pkg.sv
// Shared constants for the Tamagotchi top level: button channel map, pin polarity
// and timing derived from the system clock.
package tamagotchi_pkg;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned N_CH_DEF = 5;

  localparam int unsigned CH_SLEEP = 0;
  localparam int unsigned CH_FEED  = 1;
  localparam int unsigned CH_PLAY  = 2;
  localparam int unsigned CH_TEST  = 3;
  localparam int unsigned CH_RST   = 4;

  localparam logic [N_CH_DEF-1:0] ACTIVE_LOW_MASK_DEF = 5'b00110;

  // 20 ms debounce window, 1 s long-press threshold
  localparam int unsigned DB_CYC_DEF   = CLK_HZ / 50;
  localparam int unsigned LONG_CYC_DEF = CLK_HZ;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StHeld
  } btn_state_e;

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: 2-FF synchroniser, polarity fix, debounce, press/release/long
// classification and a press counter.
module button_channel
  import tamagotchi_pkg::*;
#(
  parameter int unsigned DB_CYC     = DB_CYC_DEF,
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned CNT_W      = 4,
  parameter bit          CNT_WRAP   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_i,
  input  logic             cnt_clr_i,
  output logic             level_o,
  output logic             press_o,
  output logic             release_o,
  output logic             long_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned      DbW      = $clog2(DB_CYC);
  localparam int unsigned      HoldW    = $clog2(LONG_CYC);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYC - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYC - 1);

  logic             sync1_q, sync2_q, s;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  btn_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  // Synchroniser resets to the released pin level so s starts at 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= ACTIVE_LOW;
      sync2_q  <= ACTIVE_LOW;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      state_q  <= StIdle;
      hold_q   <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (s != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Release has priority over the long-press threshold in the same cycle
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_o   = 1'b0;
    release_o = 1'b0;
    long_o    = 1'b0;
    case (state_q)
      StIdle: begin
        if (level_q) begin
          press_o = 1'b1;
          state_d = StPressed;
          hold_d  = '0;
        end
      end
      StPressed: begin
        if (!level_q) begin
          release_o = 1'b1;
          state_d   = StIdle;
        end else if (hold_q == HoldLast) begin
          long_o  = 1'b1;
          state_d = StHeld;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StHeld: begin
        if (!level_q) begin
          release_o = 1'b1;
          state_d   = StIdle;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear is applied before counting so a coinciding press is kept
  always_comb begin
    cnt_base = cnt_clr_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (press_o) begin
      if (cnt_base != '1) begin
        cnt_d = cnt_base + 1'b1;
      end else if (CNT_WRAP) begin
        cnt_d = '0;
      end
    end
  end

  assign level_o = level_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/button_bank.sv
// N-channel pushbutton conditioner between the board pins and FSM_Central; one
// independent button_channel per input.
module button_bank
  import tamagotchi_pkg::*;
#(
  parameter int unsigned          N_CH            = N_CH_DEF,
  parameter logic [N_CH-1:0]      ACTIVE_LOW_MASK = N_CH'(ACTIVE_LOW_MASK_DEF),
  parameter int unsigned          DB_CYC          = DB_CYC_DEF,
  parameter int unsigned          LONG_CYC        = LONG_CYC_DEF,
  parameter int unsigned          CNT_W           = 4,
  parameter bit                   CNT_WRAP        = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         btn_in,
  input  logic [N_CH-1:0]         cnt_clr,
  output logic [N_CH-1:0]         level,
  output logic [N_CH-1:0]         press_pulse,
  output logic [N_CH-1:0]         release_pulse,
  output logic [N_CH-1:0]         long_pulse,
  output logic [N_CH*CNT_W-1:0]   press_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DB_CYC     (DB_CYC),
      .LONG_CYC   (LONG_CYC),
      .CNT_W      (CNT_W),
      .CNT_WRAP   (CNT_WRAP),
      .ACTIVE_LOW (ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clk_i      (clk),
      .rst_i      (rst),
      .btn_i      (btn_in[i]),
      .cnt_clr_i  (cnt_clr[i]),
      .level_o    (level[i]),
      .press_o    (press_pulse[i]),
      .release_o  (release_pulse[i]),
      .long_o     (long_pulse[i]),
      .cnt_o      (press_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: directed scenarios plus random pins, checked against a
// cycle-indexed behavioural model of the button rules.
module tb_button_bank;

  localparam int         NCh  = 5;
  localparam int         Db   = 4;
  localparam int         Lng  = 16;
  localparam int         Cw   = 4;
  localparam logic [4:0] Mask = 5'b00110;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn_in, cnt_clr;
  logic [4:0]  level, press_pulse, release_pulse, long_pulse;
  logic [19:0] press_cnt;
  logic [4:0]  level_s, press_s, rel_s, long_s;
  logic [19:0] press_cnt_s;

  always #5 clk = ~clk;

  button_bank #(
    .N_CH(NCh), .ACTIVE_LOW_MASK(Mask), .DB_CYC(Db), .LONG_CYC(Lng), .CNT_W(Cw),
    .CNT_WRAP(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .cnt_clr(cnt_clr), .level(level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
    .press_cnt(press_cnt)
  );

  button_bank #(
    .N_CH(NCh), .ACTIVE_LOW_MASK(Mask), .DB_CYC(Db), .LONG_CYC(Lng), .CNT_W(Cw),
    .CNT_WRAP(1'b0)
  ) dut_sat (
    .clk(clk), .rst(rst), .btn_in(btn_in), .cnt_clr(cnt_clr), .level(level_s),
    .press_pulse(press_s), .release_pulse(rel_s), .long_pulse(long_s),
    .press_cnt(press_cnt_s)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: s_hist[e] is the pressed state seen after edge e; level flips once it has
  // disagreed for Db consecutive samples since the last flip or reset.
  logic [4:0]  m_d1, m_level, m_press, m_rel, m_long;
  logic [4:0]  s_hist [0:63];
  int          m_since [5];
  int          m_pedge [5];
  int          m_cnt [5];
  int          m_sat [5];
  logic [19:0] m_cnt_vec, m_sat_vec;

  task automatic model_step(input logic [4:0] pin, input logic [4:0] clr, input logic r);
    logic [4:0] new_s;
    bit         tog;
    int         c;
    cyc++;
    if (r) begin
      m_d1 = Mask;
      s_hist[cyc & 63] = '0;
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < NCh; i++) begin
        m_since[i] = cyc; m_pedge[i] = -1000000; m_cnt[i] = 0; m_sat[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCh; i++) begin
        c = clr[i] ? 0 : m_cnt[i];
        if (m_press[i]) c = (c + 1) % 16;
        m_cnt[i] = c;
        c = clr[i] ? 0 : m_sat[i];
        if (m_press[i] && c < 15) c = c + 1;
        m_sat[i] = c;
      end
      new_s = m_d1 ^ Mask;
      m_d1  = pin;
      s_hist[cyc & 63] = new_s;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < NCh; i++) begin
        tog = 1'b0;
        if (cyc - Db >= m_since[i]) begin
          tog = 1'b1;
          for (int j = 1; j <= Db; j++) begin
            if (s_hist[(cyc - j) & 63][i] == m_level[i]) tog = 1'b0;
          end
        end
        if (tog) begin
          m_level[i] = ~m_level[i];
          m_since[i] = cyc;
          if (m_level[i]) begin
            m_press[i] = 1'b1;
            m_pedge[i] = cyc;
          end else begin
            m_rel[i] = 1'b1;
          end
        end else if (m_level[i] && (cyc - m_pedge[i] == Lng)) begin
          m_long[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NCh; i++) begin
      m_cnt_vec[i*Cw +: Cw] = 4'(m_cnt[i]);
      m_sat_vec[i*Cw +: Cw] = 4'(m_sat[i]);
    end
  endtask

  task automatic tick();
    logic [4:0] p, c;
    logic       r;
    p = btn_in; c = cnt_clr; r = rst;
    @(posedge clk);
    #1;
    model_step(p, c, r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({level, press_pulse, release_pulse, long_pulse, press_cnt, press_cnt_s} !== '0) begin
      errors++;
      $display("FAIL reset_values got lvl=%b pr=%b rl=%b lg=%b cnt=%h sat=%h required all 0",
               level, press_pulse, release_pulse, long_pulse, press_cnt, press_cnt_s);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({level, press_pulse, release_pulse, long_pulse} !== {m_level, m_press, m_rel, m_long}
          || press_cnt !== m_cnt_vec) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got lvl=%b pr=%b cnt=%h required lvl=%b pr=%b cnt=%h",
                 cyc, level, press_pulse, press_cnt, m_level, m_press, m_cnt_vec);
      end
    end
  endtask

  task automatic test_glitch();
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) btn_in[0] = 1'b0;
      checks++;
      if (level[0] !== 1'b0 || press_pulse[0] !== 1'b0 || press_cnt[3:0] !== 4'd0) begin
        errors++;
        $display("FAIL glitch_reject k=%0d got lvl=%b pr=%b cnt=%0d required 0 0 0",
                 k, level[0], press_pulse[0], press_cnt[3:0]);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 40) btn_in[0] = 1'b0;
      checks++;
      if (press_pulse[0] !== (k == 6) || long_pulse[0] !== (k == 22)
          || release_pulse[0] !== (k == 46)) begin
        errors++;
        $display("FAIL clean_press k=%0d got pr=%b lg=%b rl=%b required pr=%b lg=%b rl=%b",
                 k, press_pulse[0], long_pulse[0], release_pulse[0], k == 6, k == 22, k == 46);
      end
      checks++;
      if ({level, press_pulse, release_pulse, long_pulse} !== {m_level, m_press, m_rel, m_long}
          || press_cnt !== m_cnt_vec || press_cnt_s !== m_sat_vec) begin
        errors++;
        $display("FAIL clean_model cyc=%0d got lvl=%b cnt=%h required lvl=%b cnt=%h",
                 cyc, level, press_cnt, m_level, m_cnt_vec);
      end
    end
    checks++;
    if (press_cnt[3:0] !== 4'd1) begin
      errors++;
      $display("FAIL clean_count got %0d required 1", press_cnt[3:0]);
    end
  endtask

  task automatic test_active_low();
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if ({level[1], press_pulse[1], release_pulse[1], long_pulse[1]} !== 4'b0) begin
        errors++;
        $display("FAIL active_low_idle k=%0d got lvl=%b pr=%b rl=%b lg=%b required 0",
                 k, level[1], press_pulse[1], release_pulse[1], long_pulse[1]);
      end
    end
    btn_in[1] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 10) btn_in[1] = 1'b1;
      checks++;
      if (press_pulse[1] !== (k == 6) || release_pulse[1] !== (k == 16)
          || long_pulse[1] !== 1'b0 || level[1] !== (k >= 6 && k < 16)) begin
        errors++;
        $display("FAIL active_low_press k=%0d got lvl=%b pr=%b rl=%b lg=%b required %b %b %b 0",
                 k, level[1], press_pulse[1], release_pulse[1], long_pulse[1],
                 k >= 6 && k < 16, k == 6, k == 16);
      end
    end
  endtask

  task automatic test_wrap_clear();
    for (int n = 0; n < 16; n++) begin
      btn_in[3] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
        tick();
        if (k == 8) btn_in[3] = 1'b0;
        checks++;
        if (press_cnt !== m_cnt_vec || press_cnt_s !== m_sat_vec || press_pulse !== m_press) begin
          errors++;
          $display("FAIL wrap_model cyc=%0d got cnt=%h sat=%h required cnt=%h sat=%h",
                   cyc, press_cnt, press_cnt_s, m_cnt_vec, m_sat_vec);
        end
      end
    end
    checks++;
    if (press_cnt[15:12] !== 4'd0 || press_cnt_s[15:12] !== 4'd15) begin
      errors++;
      $display("FAIL wrap_16 got wrap=%0d sat=%0d required 0 15",
               press_cnt[15:12], press_cnt_s[15:12]);
    end
    btn_in[3] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 6) begin
        checks++;
        if (press_pulse[3] !== 1'b1) begin
          errors++;
          $display("FAIL clr_press_pulse got %b required 1", press_pulse[3]);
        end
        cnt_clr[3] = 1'b1;
      end
      if (k == 7) begin
        cnt_clr[3] = 1'b0;
        checks++;
        if (press_cnt[15:12] !== 4'd1 || press_cnt_s[15:12] !== 4'd1) begin
          errors++;
          $display("FAIL clr_with_press got wrap=%0d sat=%0d required 1 1",
                   press_cnt[15:12], press_cnt_s[15:12]);
        end
      end
      if (k == 10) btn_in[3] = 1'b0;
      if (k == 20) cnt_clr[3] = 1'b1;
      if (k == 21) begin
        cnt_clr[3] = 1'b0;
        checks++;
        if (press_cnt[15:12] !== 4'd0 || press_cnt_s[15:12] !== 4'd0) begin
          errors++;
          $display("FAIL clr_alone got wrap=%0d sat=%0d required 0 0",
                   press_cnt[15:12], press_cnt_s[15:12]);
        end
      end
    end
  endtask

  task automatic test_long_boundary();
    for (int d = 16; d <= 17; d++) begin
      btn_in[0] = 1'b1;
      for (int k = 1; k <= 34; k++) begin
        tick();
        if (k == d) btn_in[0] = 1'b0;
        checks++;
        if (long_pulse[0] !== (d == 17 && k == 22) || release_pulse[0] !== (k == d + 6)) begin
          errors++;
          $display("FAIL long_boundary d=%0d k=%0d got lg=%b rl=%b required lg=%b rl=%b",
                   d, k, long_pulse[0], release_pulse[0], d == 17 && k == 22, k == d + 6);
        end
      end
    end
  endtask

  task automatic test_concurrency_reset();
    btn_in[0] = 1'b1;
    btn_in[2] = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      checks++;
      if (press_pulse[0] !== (k == 6) || press_pulse[2] !== (k == 6)
          || long_pulse[0] !== (k == 22) || long_pulse[2] !== (k == 22)) begin
        errors++;
        $display("FAIL concurrent k=%0d got pr=%b lg=%b required ch0/ch2 pr=%b lg=%b",
                 k, press_pulse, long_pulse, k == 6, k == 22);
      end
    end
    rst = 1'b1;
    btn_in = Mask;
    tick();
    rst = 1'b0;
    checks++;
    if ({level, press_pulse, release_pulse, long_pulse, press_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_held got lvl=%b pr=%b rl=%b lg=%b cnt=%h required all 0",
               level, press_pulse, release_pulse, long_pulse, press_cnt);
    end
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (release_pulse !== 5'b0 || level !== m_level) begin
        errors++;
        $display("FAIL reset_no_release k=%0d got rl=%b lvl=%b required rl=0 lvl=%b",
                 k, release_pulse, level, m_level);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NCh; i++) begin
        if ($urandom_range(0, 9) == 0) btn_in[i] = ~btn_in[i];
        cnt_clr[i] = ($urandom_range(0, 39) == 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if ({level, press_pulse, release_pulse, long_pulse} !== {m_level, m_press, m_rel, m_long}
          || {level_s, press_s, rel_s, long_s} !== {m_level, m_press, m_rel, m_long}
          || press_cnt !== m_cnt_vec || press_cnt_s !== m_sat_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got lvl=%b pr=%b rl=%b lg=%b cnt=%h sat=%h required lvl=%b pr=%b rl=%b lg=%b cnt=%h sat=%h",
                 cyc, level, press_pulse, release_pulse, long_pulse, press_cnt, press_cnt_s,
                 m_level, m_press, m_rel, m_long, m_cnt_vec, m_sat_vec);
      end
    end
    rst = 1'b0;
    cnt_clr = '0;
  endtask

  initial begin
    rst     = 1'b1;
    btn_in  = Mask;
    cnt_clr = '0;
    m_d1    = Mask;
    m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    m_cnt_vec = '0; m_sat_vec = '0;
    for (int i = 0; i < 64; i++) s_hist[i] = '0;
    for (int i = 0; i < NCh; i++) begin
      m_since[i] = 0; m_pedge[i] = -1000000; m_cnt[i] = 0; m_sat[i] = 0;
    end
    test_reset();
    test_glitch();
    test_clean_press();
    test_active_low();
    test_wrap_clear();
    test_long_boundary();
    test_concurrency_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
